// File: rtl/branch_cmp_stage.sv
// Registered RV32I branch-compare stage with a 2-entry skid buffer.
// Optional subtractor self-check is enabled by defining BRANCH_CMP_SUBCHECK_EN.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main register holds the presented beat
// TWO   | main presented, skid holds the next beat, in_ready=0
module branch_cmp_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [31:0]      in_diff,
  input  logic [2:0]       in_funct3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_illegal,
  output logic             out_zero,
  output logic             out_lt,
  output logic             out_ltu,
  output logic [TAG_W-1:0] out_tag,
  output logic             sub_err
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam int BEAT_W = TAG_W + 5;

  state_t              state;
  logic [BEAT_W-1:0]   main_q;
  logic [BEAT_W-1:0]   skid_q;
  logic [BEAT_W-1:0]   new_beat;
  logic                acc;
  logic                pop;
  logic                zero_c;
  logic                lt_c;
  logic                ltu_c;
  logic                taken_c;
  logic                illegal_c;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  // Sign-split compare avoids a 33-bit subtract: differing signs decide directly.
  always_comb begin
    zero_c    = (in_diff == 32'd0);
    lt_c      = (in_a[31] != in_b[31]) ? in_a[31] : in_diff[31];
    ltu_c     = (in_a[31] != in_b[31]) ? in_b[31] : in_diff[31];
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (in_funct3)
      3'b000:  taken_c = zero_c;
      3'b001:  taken_c = !zero_c;
      3'b100:  taken_c = lt_c;
      3'b101:  taken_c = !lt_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = !ltu_c;
      default: illegal_c = 1'b1;
    endcase
  end

  assign new_beat = {taken_c, illegal_c, zero_c, lt_c, ltu_c, in_tag};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q    <= new_beat;
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            skid_q   <= new_beat;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (acc && pop) begin
            main_q <= new_beat;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_taken   = main_q[TAG_W+4];
  assign out_illegal = main_q[TAG_W+3];
  assign out_zero    = main_q[TAG_W+2];
  assign out_lt      = main_q[TAG_W+1];
  assign out_ltu     = main_q[TAG_W];
  assign out_tag     = main_q[TAG_W-1:0];

`ifdef BRANCH_CMP_SUBCHECK_EN
  logic [31:0] diff_ref;
  assign diff_ref = in_a + ~in_b + 32'd1;

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sub_err <= 1'b0;
    else if (acc && (in_diff != diff_ref))
      sub_err <= 1'b1;
  end
`else
  assign sub_err = 1'b0;
`endif

endmodule

// File: tb/tb_branch_cmp_stage.sv
// Directed self-checking bench for branch_cmp_stage; expected values are hand-computed.
// Honours BRANCH_CMP_SUBCHECK_EN when choosing the expected sub_err value.
module tb_branch_cmp_stage;

  localparam int TAG_W = 8;
`ifdef BRANCH_CMP_SUBCHECK_EN
  localparam logic EXP_SE = 1'b1;
`else
  localparam logic EXP_SE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_diff;
  logic [2:0]       in_funct3;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_illegal;
  logic             out_zero;
  logic             out_lt;
  logic             out_ltu;
  logic [TAG_W-1:0] out_tag;
  logic             sub_err;

  int errors = 0;
  int checks = 0;

  branch_cmp_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_diff(in_diff),
    .in_funct3(in_funct3), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_illegal(out_illegal),
    .out_zero(out_zero), .out_lt(out_lt), .out_ltu(out_ltu),
    .out_tag(out_tag), .sub_err(sub_err)
  );

  always #5 clk = ~clk;

  // {out_valid, out_taken, out_illegal, out_zero, out_lt, out_ltu}
  wire [5:0] obs = {out_valid, out_taken, out_illegal, out_zero, out_lt, out_ltu};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                       input logic [2:0] f3, input logic [TAG_W-1:0] tag);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_diff   = d;
    in_funct3 = f3;
    in_tag    = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (obs !== 6'b000000 || in_ready !== 1'b1 || out_tag !== 8'd0 || sub_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: flags=%b in_ready=%b tag=%0d sub_err=%b, want flags=000000 in_ready=1 tag=0 sub_err=0",
               obs, in_ready, out_tag, sub_err);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_eq_ne();
    out_ready = 1'b1;
    drive(32'd5, 32'd5, 32'd0, 3'b000, 8'd10);
    step();
    checks++;
    if (obs !== 6'b110100 || out_tag !== 8'd10) begin
      errors++;
      $display("FAIL beq: flags=%b tag=%0d, want 110100 tag=10", obs, out_tag);
    end
    drive(32'd5, 32'd5, 32'd0, 3'b001, 8'd11);
    step();
    checks++;
    if (obs !== 6'b100100 || out_tag !== 8'd11 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bne: flags=%b tag=%0d in_ready=%b, want 100100 tag=11 in_ready=1", obs, out_tag, in_ready);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_eq: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_signed_unsigned();
    out_ready = 1'b1;
    drive(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 3'b100, 8'd20);
    step();
    checks++;
    if (obs !== 6'b110010 || out_tag !== 8'd20) begin
      errors++;
      $display("FAIL blt_neg: flags=%b tag=%0d, want 110010 tag=20", obs, out_tag);
    end
    drive(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 3'b110, 8'd21);
    step();
    checks++;
    if (obs !== 6'b100010 || out_tag !== 8'd21) begin
      errors++;
      $display("FAIL bltu_big: flags=%b tag=%0d, want 100010 tag=21", obs, out_tag);
    end
    drive(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b101, 8'd22);
    step();
    checks++;
    if (obs !== 6'b100010 || out_tag !== 8'd22) begin
      errors++;
      $display("FAIL bge_ovf: flags=%b tag=%0d, want 100010 tag=22", obs, out_tag);
    end
    drive(32'd3, 32'd7, 32'hFFFF_FFFC, 3'b111, 8'd23);
    step();
    checks++;
    if (obs !== 6'b100011 || out_tag !== 8'd23 || sub_err !== 1'b0) begin
      errors++;
      $display("FAIL bgeu_small: flags=%b tag=%0d sub_err=%b, want 100011 tag=23 sub_err=0", obs, out_tag, sub_err);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 3'b000, 8'd1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b tag=%0d in_ready=%b, want 1 1 1", out_valid, out_tag, in_ready);
    end
    drive(32'd0, 32'd0, 32'd0, 3'b000, 8'd2);
    step();
    checks++;
    if (out_tag !== 8'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: tag=%0d in_ready=%b, want tag=1 in_ready=0", out_tag, in_ready);
    end
    drive(32'd0, 32'd0, 32'd0, 3'b000, 8'd3);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: out_valid=%b tag=%0d in_ready=%b, want 1 1 0", out_valid, out_tag, in_ready);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop1: out_valid=%b tag=%0d in_ready=%b, want 1 2 1", out_valid, out_tag, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 8'd3) begin
      errors++;
      $display("FAIL bp_pop2: out_valid=%b tag=%0d, want 1 3", out_valid, out_tag);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    drive(32'd1, 32'd2, 32'hFFFF_FFFF, 3'b100, 8'd41);
    step();
    drive(32'd1, 32'd2, 32'hFFFF_FFFF, 3'b100, 8'd42);
    step();
    drive(32'd1, 32'd2, 32'hFFFF_FFFF, 3'b100, 8'd43);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    // One held beat plus an accepted beat in the flush cycle.
    drive(32'd1, 32'd2, 32'hFFFF_FFFF, 3'b100, 8'd51);
    step();
    drive(32'd1, 32'd2, 32'hFFFF_FFFF, 3'b100, 8'd52);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_discard: out_valid seen %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_subcheck();
    out_ready = 1'b1;
    drive(32'd10, 32'd3, 32'd8, 3'b011, 8'd60);
    step();
    in_valid = 1'b0;
    checks++;
    if (obs !== 6'b101000 || out_tag !== 8'd60 || sub_err !== EXP_SE) begin
      errors++;
      $display("FAIL subcheck: flags=%b tag=%0d sub_err=%b, want 101000 tag=60 sub_err=%b", obs, out_tag, sub_err, EXP_SE);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (sub_err !== EXP_SE || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sub_err_sticky: sub_err=%b out_valid=%b, want %b 0", sub_err, out_valid, EXP_SE);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(32'd9, 32'd9, 32'd0, 3'b000, 8'd70);
    step();
    drive(32'd9, 32'd9, 32'd0, 3'b000, 8'd71);
    step();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b000000 || in_ready !== 1'b1 || out_tag !== 8'd0 || sub_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: flags=%b in_ready=%b tag=%0d sub_err=%b, want 000000 1 0 0",
               obs, in_ready, out_tag, sub_err);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: out_valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_diff   = '0;
    in_funct3 = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_eq_ne();
    test_signed_unsigned();
    test_backpressure();
    test_flush();
    test_subcheck();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
